// File: rtl/reg_mod_bank.sv
// Tap/delay register bank for the trapezoidal filter datapath.
// Optional clock enable port ce is built in when REG_MOD_CE_EN is defined.
module reg_mod_bank #(
    parameter int ADC_W = 14,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
`ifdef REG_MOD_CE_EN
    input  logic             ce,
`endif
    input  logic [ADC_W-1:0] data,
    input  logic [ACC_W-1:0] s_in,
    input  logic [ACC_W-1:0] p_in,
    output logic [ADC_W-1:0] x0,
    output logic [ADC_W-1:0] x1,
    output logic [ADC_W-1:0] x2,
    output logic [ADC_W-1:0] x3,
    output logic [ADC_W-1:0] x4,
    output logic [ADC_W-1:0] x5,
    output logic [ADC_W-1:0] x6,
    output logic [ADC_W-1:0] x7,
    output logic [ADC_W-1:0] x8,
    output logic [ADC_W-1:0] x9,
    output logic [ADC_W-1:0] x10,
    output logic [ACC_W-1:0] s0,
    output logic [ACC_W-1:0] s1,
    output logic [ACC_W-1:0] p0,
    output logic [ACC_W-1:0] p1
);

    localparam int TAPS = 10;

    logic [ADC_W-1:0] r_q [1:TAPS];
    logic [ADC_W-1:0] r_d [1:TAPS];
    logic [ACC_W-1:0] rs_q, rs_d;
    logic [ACC_W-1:0] rp_q, rp_d;
    logic             upd;

`ifdef REG_MOD_CE_EN
    assign upd = ce;
`else
    assign upd = 1'b1;
`endif

    // Next state: shift the sample line and capture feedback inputs, or hold.
    always_comb begin
        r_d  = r_q;
        rs_d = rs_q;
        rp_d = rp_q;
        if (upd) begin
            r_d[1] = data;
            for (int k = 2; k <= TAPS; k++) begin
                r_d[k] = r_q[k-1];
            end
            rs_d = s_in;
            rp_d = p_in;
        end
    end

    // State registers; reset clears all history at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= TAPS; k++) begin
                r_q[k] <= '0;
            end
            rs_q <= '0;
            rp_q <= '0;
        end else begin
            r_q  <= r_d;
            rs_q <= rs_d;
            rp_q <= rp_d;
        end
    end

    assign x0  = data;
    assign x1  = r_q[1];
    assign x2  = r_q[2];
    assign x3  = r_q[3];
    assign x4  = r_q[4];
    assign x5  = r_q[5];
    assign x6  = r_q[6];
    assign x7  = r_q[7];
    assign x8  = r_q[8];
    assign x9  = r_q[9];
    assign x10 = r_q[10];

    assign s0 = s_in;
    assign s1 = rs_q;
    assign p0 = p_in;
    assign p1 = rp_q;

endmodule

// File: tb/tb_reg_mod_bank.sv
// Directed testbench for reg_mod_bank.
// Covers the REG_MOD_CE_EN clock enable when that macro is defined.
module tb_reg_mod_bank;

    localparam int ADC_W = 14;
    localparam int ACC_W = 24;

    logic             clk;
    logic             reset;
`ifdef REG_MOD_CE_EN
    logic             ce;
`endif
    logic [ADC_W-1:0] data;
    logic [ACC_W-1:0] s_in;
    logic [ACC_W-1:0] p_in;
    logic [ADC_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10;
    logic [ACC_W-1:0] s0, s1, p0, p1;
    logic [ADC_W-1:0] xt [0:10];

    int checks;
    int errors;

    reg_mod_bank #(
        .ADC_W(ADC_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
`ifdef REG_MOD_CE_EN
        .ce   (ce),
`endif
        .data (data),
        .s_in (s_in),
        .p_in (p_in),
        .x0   (x0),
        .x1   (x1),
        .x2   (x2),
        .x3   (x3),
        .x4   (x4),
        .x5   (x5),
        .x6   (x6),
        .x7   (x7),
        .x8   (x8),
        .x9   (x9),
        .x10  (x10),
        .s0   (s0),
        .s1   (s1),
        .p0   (p0),
        .p1   (p1)
    );

    assign xt[0]  = x0;
    assign xt[1]  = x1;
    assign xt[2]  = x2;
    assign xt[3]  = x3;
    assign xt[4]  = x4;
    assign xt[5]  = x5;
    assign xt[6]  = x6;
    assign xt[7]  = x7;
    assign xt[8]  = x8;
    assign xt[9]  = x9;
    assign xt[10] = x10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse between edges.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data  = 14'd5;
        s_in  = 24'd9;
        p_in  = 24'd3;
        #2;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (xt[k] !== '0) begin
                errors++;
                $display("FAIL reset_tap k=%0d got %0h exp 0", k, xt[k]);
            end
        end
        checks++;
        if (x0 !== 14'd5) begin
            errors++;
            $display("FAIL reset_x0 got %0h exp 5", x0);
        end
        checks++;
        if (s1 !== '0 || p1 !== '0) begin
            errors++;
            $display("FAIL reset_sp1 got s1=%0h p1=%0h exp 0", s1, p1);
        end
        checks++;
        if (s0 !== 24'd9 || p0 !== 24'd3) begin
            errors++;
            $display("FAIL reset_sp0 got s0=%0h p0=%0h exp 9/3", s0, p0);
        end
        tick();
        checks++;
        if (x1 !== '0 || s1 !== '0) begin
            errors++;
            $display("FAIL reset_held got x1=%0h s1=%0h exp 0", x1, s1);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_impulse();
        logic [ADC_W-1:0] exp_v;
        do_reset();
        data = 14'd100;
        #1;
        for (int k = 0; k <= 10; k++) begin
            exp_v = (k == 0) ? 14'd100 : 14'd0;
            checks++;
            if (xt[k] !== exp_v) begin
                errors++;
                $display("FAIL impulse c=0 k=%0d got %0h exp %0h",
                         k, xt[k], exp_v);
            end
        end
        for (int c = 1; c <= 11; c++) begin
            tick();
            data = '0;
            #1;
            for (int k = 0; k <= 10; k++) begin
                exp_v = (k == c) ? 14'd100 : 14'd0;
                checks++;
                if (xt[k] !== exp_v) begin
                    errors++;
                    $display("FAIL impulse c=%0d k=%0d got %0h exp %0h",
                             c, k, xt[k], exp_v);
                end
            end
        end
    endtask

    task automatic test_ramp();
        logic [ADC_W-1:0] exp_v;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            data = ADC_W'(n);
            #1;
            for (int k = 0; k <= 10; k++) begin
                exp_v = (n - k > 0) ? ADC_W'(n - k) : 14'd0;
                checks++;
                if (xt[k] !== exp_v) begin
                    errors++;
                    $display("FAIL ramp n=%0d k=%0d got %0d exp %0d",
                             n, k, xt[k], exp_v);
                end
            end
            tick();
        end
    endtask

    task automatic test_feedback();
        logic [ACC_W-1:0] es, ep;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_in = ACC_W'(17 * (i + 1));
            p_in = ACC_W'(i + 1);
            #1;
            es = ACC_W'(17 * i);
            ep = ACC_W'(i);
            checks++;
            if (s0 !== s_in || p0 !== p_in) begin
                errors++;
                $display("FAIL fb_pass i=%0d got s0=%0d p0=%0d exp %0d/%0d",
                         i, s0, p0, s_in, p_in);
            end
            checks++;
            if (s1 !== es) begin
                errors++;
                $display("FAIL fb_s1 i=%0d got %0d exp %0d", i, s1, es);
            end
            checks++;
            if (p1 !== ep) begin
                errors++;
                $display("FAIL fb_p1 i=%0d got %0d exp %0d", i, p1, ep);
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        logic [ADC_W-1:0] exp_v;
        do_reset();
        s_in = 24'd77;
        p_in = 24'd88;
        for (int n = 1; n <= 12; n++) begin
            data = ADC_W'(n);
            tick();
        end
        checks++;
        if (x1 !== 14'd12 || x10 !== 14'd3 || s1 !== 24'd77) begin
            errors++;
            $display("FAIL mid_fill got x1=%0d x10=%0d s1=%0d exp 12/3/77",
                     x1, x10, s1);
        end
        data  = 14'd50;
        reset = 1'b0;
        #1;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (xt[k] !== '0) begin
                errors++;
                $display("FAIL mid_clear k=%0d got %0h exp 0", k, xt[k]);
            end
        end
        checks++;
        if (s1 !== '0 || p1 !== '0 || x0 !== 14'd50) begin
            errors++;
            $display("FAIL mid_clear_sp got s1=%0h p1=%0h x0=%0d exp 0/0/50",
                     s1, p1, x0);
        end
        reset = 1'b1;
        #1;
        data = 14'd7;
        tick();
        data = '0;
        tick();
        tick();
        for (int k = 1; k <= 10; k++) begin
            exp_v = (k == 3) ? 14'd7 : 14'd0;
            checks++;
            if (xt[k] !== exp_v) begin
                errors++;
                $display("FAIL mid_refill k=%0d got %0d exp %0d",
                         k, xt[k], exp_v);
            end
        end
    endtask

    task automatic test_wide();
        do_reset();
        data = 14'h3FFF;
        s_in = 24'hFFFFFF;
        p_in = 24'h800001;
        repeat (10) tick();
        checks++;
        if (x10 !== 14'h3FFF) begin
            errors++;
            $display("FAIL wide_x10 got %0h exp 3fff", x10);
        end
        checks++;
        if (s1 !== 24'hFFFFFF || p1 !== 24'h800001) begin
            errors++;
            $display("FAIL wide_sp got s1=%0h p1=%0h exp ffffff/800001",
                     s1, p1);
        end
        data = 14'h2001;
        tick();
        data = 14'h0;
        tick();
        checks++;
        if (x2 !== 14'h2001 || x1 !== 14'h0 || x3 !== 14'h3FFF) begin
            errors++;
            $display("FAIL wide_signed got x1=%0h x2=%0h x3=%0h exp 0/2001/3fff",
                     x1, x2, x3);
        end
    endtask

`ifdef REG_MOD_CE_EN
    task automatic test_ce();
        do_reset();
        ce = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            data = ADC_W'(n);
            s_in = ACC_W'(n * 10);
            p_in = ACC_W'(n * 20);
            tick();
        end
        data = 14'd99;
        s_in = 24'd999;
        p_in = 24'd888;
        ce   = 1'b0;
        repeat (3) tick();
        checks++;
        if (x1 !== 14'd5 || x5 !== 14'd1 || x6 !== 14'd0) begin
            errors++;
            $display("FAIL ce_hold got x1=%0d x5=%0d x6=%0d exp 5/1/0",
                     x1, x5, x6);
        end
        checks++;
        if (s1 !== 24'd50 || p1 !== 24'd100 || x0 !== 14'd99) begin
            errors++;
            $display("FAIL ce_hold_sp got s1=%0d p1=%0d x0=%0d exp 50/100/99",
                     s1, p1, x0);
        end
        ce = 1'b1;
        tick();
        checks++;
        if (x1 !== 14'd99 || x2 !== 14'd5 || x6 !== 14'd1 || s1 !== 24'd999) begin
            errors++;
            $display("FAIL ce_resume got x1=%0d x2=%0d x6=%0d s1=%0d exp 99/5/1/999",
                     x1, x2, x6, s1);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
`ifdef REG_MOD_CE_EN
        ce = 1'b1;
`endif
        test_reset();
        test_impulse();
        test_ramp();
        test_feedback();
        test_midreset();
        test_wide();
`ifdef REG_MOD_CE_EN
        test_ce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
